// File: rtl/dl_tx_scheduler_if.sv
// Requester/controller bundle for the downlink transmit scheduler.
// master: requesters plus downlink controller side; slave: the scheduler.
interface dl_tx_scheduler_if #(
  parameter int unsigned NUM_REQ = 2
);
  logic [NUM_REQ-1:0]   req;
  logic [NUM_REQ-1:0]   req_enc;
  logic [NUM_REQ*8-1:0] req_len;
  logic [NUM_REQ*4-1:0] req_tag;
  logic [NUM_REQ-1:0]   gnt;
  logic [NUM_REQ-1:0]   cmpl;
  logic                 dl_start;
  logic                 enc_used;
  logic [7:0]           msg_len;
  logic [3:0]           msg_tag;
  logic                 dl_done;

  modport master (
    output req, req_enc, req_len, req_tag, dl_done,
    input  gnt, cmpl, dl_start, enc_used, msg_len, msg_tag
  );

  modport slave (
    input  req, req_enc, req_len, req_tag, dl_done,
    output gnt, cmpl, dl_start, enc_used, msg_len, msg_tag
  );
endinterface

// File: rtl/dl_tx_scheduler.sv
// Downlink transmit scheduler: round-robin ownership of the single downlink
// framing controller, parameter latching, start/done tracking, optional
// inter-frame gap and a completion watchdog.
// Build option: define DL_SCHED_IFG_EN to enable the inter-frame gap state
// (S_GAP) and honour gap_cycles; without it completion returns straight to idle.
module dl_tx_scheduler #(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned GAP_W   = 16,
  parameter int unsigned TO_W    = 20
) (
  input  logic                clk,
  input  logic                rst_n,
  dl_tx_scheduler_if.slave    bus,
  input  logic [GAP_W-1:0]    gap_cycles,
  input  logic [TO_W-1:0]     timeout_cycles,
  output logic                busy,
  output logic                timeout_err,
  input  logic                err_clr
);

  localparam int unsigned PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_WAIT_BUSY,
    S_WAIT_DONE
`ifdef DL_SCHED_IFG_EN
    , S_GAP
`endif
  } state_t;

  state_t             r_state;
  logic [PTR_W-1:0]   r_ptr;
  logic [NUM_REQ-1:0] r_gnt;
  logic [NUM_REQ-1:0] r_cmpl;
  logic               r_dl_start;
  logic               r_enc;
  logic [7:0]         r_len;
  logic [3:0]         r_tag;
  logic               r_busy;
  logic               r_timeout_err;
  logic [TO_W-1:0]    r_wd;
`ifdef DL_SCHED_IFG_EN
  logic [GAP_W-1:0]   r_gap;
`else
  logic               w_unused_gap;
  assign w_unused_gap = ^gap_cycles;
`endif

  logic               w_any;
  logic [PTR_W-1:0]   w_win;
  logic [PTR_W-1:0]   w_cand;
  logic               w_wd_hit;
  logic [7:0]         w_len_arr [NUM_REQ];
  logic [3:0]         w_tag_arr [NUM_REQ];

  // Split the flat per-requester length/tag buses into indexable lanes.
  for (genvar g = 0; g < NUM_REQ; g++) begin : g_lane
    assign w_len_arr[g] = bus.req_len[g*8 +: 8];
    assign w_tag_arr[g] = bus.req_tag[g*4 +: 4];
  end

  // Round-robin search starting one above the last winner; lowest offset wins.
  always_comb begin
    w_any  = 1'b0;
    w_win  = '0;
    w_cand = '0;
    for (int k = int'(NUM_REQ); k >= 1; k--) begin
      w_cand = PTR_W'((int'(r_ptr) + k) % int'(NUM_REQ));
      if (bus.req[w_cand]) begin
        w_any = 1'b1;
        w_win = w_cand;
      end
    end
  end

  // Watchdog expiry; a zero limit disables it.
  assign w_wd_hit = (timeout_cycles != '0) && (r_wd == timeout_cycles);

  // Scheduler state machine with all outputs registered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= S_IDLE;
      r_ptr         <= '0;
      r_gnt         <= '0;
      r_cmpl        <= '0;
      r_dl_start    <= 1'b0;
      r_enc         <= 1'b0;
      r_len         <= '0;
      r_tag         <= '0;
      r_busy        <= 1'b0;
      r_timeout_err <= 1'b0;
      r_wd          <= '0;
`ifdef DL_SCHED_IFG_EN
      r_gap         <= '0;
`endif
    end else begin
      r_dl_start <= 1'b0;
      r_cmpl     <= '0;
      // Clear first so a simultaneous watchdog set below takes precedence.
      if (err_clr) begin
        r_timeout_err <= 1'b0;
      end
      case (r_state)
        S_IDLE: begin
          if (w_any) begin
            r_gnt   <= NUM_REQ'(1) << w_win;
            r_enc   <= bus.req_enc[w_win];
            r_len   <= w_len_arr[w_win];
            r_tag   <= w_tag_arr[w_win];
            r_ptr   <= w_win;
            r_busy  <= 1'b1;
            r_state <= S_START;
          end
        end
        S_START: begin
          r_dl_start <= 1'b1;
          r_wd       <= '0;
          r_state    <= S_WAIT_BUSY;
        end
        S_WAIT_BUSY: begin
          if (w_wd_hit) begin
            r_timeout_err <= 1'b1;
            r_cmpl        <= r_gnt;
            r_gnt         <= '0;
            r_busy        <= 1'b0;
            r_state       <= S_IDLE;
          end else begin
            r_wd <= r_wd + TO_W'(1);
            if (!bus.dl_done) begin
              r_state <= S_WAIT_DONE;
            end
          end
        end
        S_WAIT_DONE: begin
          if (bus.dl_done) begin
            r_cmpl <= r_gnt;
            r_gnt  <= '0;
`ifdef DL_SCHED_IFG_EN
            if (gap_cycles != '0) begin
              r_gap   <= gap_cycles;
              r_state <= S_GAP;
            end else begin
              r_busy  <= 1'b0;
              r_state <= S_IDLE;
            end
`else
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
`endif
          end else if (w_wd_hit) begin
            r_timeout_err <= 1'b1;
            r_cmpl        <= r_gnt;
            r_gnt         <= '0;
            r_busy        <= 1'b0;
            r_state       <= S_IDLE;
          end else begin
            r_wd <= r_wd + TO_W'(1);
          end
        end
`ifdef DL_SCHED_IFG_EN
        S_GAP: begin
          if (r_gap <= GAP_W'(1)) begin
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end else begin
            r_gap <= r_gap - GAP_W'(1);
          end
        end
`endif
        default: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.gnt      = r_gnt;
  assign bus.cmpl     = r_cmpl;
  assign bus.dl_start = r_dl_start;
  assign bus.enc_used = r_enc;
  assign bus.msg_len  = r_len;
  assign bus.msg_tag  = r_tag;
  assign busy         = r_busy;
  assign timeout_err  = r_timeout_err;

endmodule
